// File: rtl/sigmoid_output_layer.sv
// sigmoid_output_layer: one output neuron of the sigmoid network.
// Latches N_IN hidden activations on req. Runs a sequential MAC, adds the bias,
// then applies a piecewise-linear sigmoid (0.25*z + 0.5, clamped to 0..1 in Q4).
// The result is returned over a level req/ack handshake.
// Optional build macro OUTLAYER_SAT_EN: when defined, z saturates to the
// DATA_W signed range; when undefined, z is the two's-complement wrap of the sum.
module sigmoid_output_layer #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 8,
  parameter int FRAC   = 4,
  parameter int ACC_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [N_IN*DATA_W-1:0]     x_in,
  input  logic                       cfg_we,
  input  logic [$clog2(N_IN+1)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]          cfg_data,
  output logic                       ack,
  output logic [DATA_W-1:0]          z_out,
  output logic [DATA_W-1:0]          y_out
);

  localparam int AW = $clog2(N_IN + 1);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = 2 * DATA_W;

  // 0.5 and 1.0 in the activation's fixed-point format
  localparam logic signed [DATA_W-1:0] Y_HALF = DATA_W'(32'sd1 <<< (FRAC - 1));
  localparam logic signed [DATA_W-1:0] Y_ONE  = DATA_W'(32'sd1 <<< FRAC);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_BIAS = 3'd2,
    ST_ACT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic signed [DATA_W-1:0]  w_r [N_IN];
  logic signed [DATA_W-1:0]  bias_r;
  logic signed [DATA_W-1:0]  x_r [N_IN];
  logic signed [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic [IW-1:0]             idx_r, idx_nxt_s;
  logic                      ack_r, ack_nxt_s;
  logic signed [DATA_W-1:0]  z_r, z_nxt_s;
  logic signed [DATA_W-1:0]  y_r, y_nxt_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [ACC_W-1:0]   term_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic                      cfg_ok_s;
  logic                      mac_last_s;

  // Reduce the accumulator-width sum to DATA_W (saturating or wrapping).
  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] s);
`ifdef OUTLAYER_SAT_EN
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (s > hi) begin
      narrow = hi[DATA_W-1:0];
    end else if (s < lo) begin
      narrow = lo[DATA_W-1:0];
    end else begin
      narrow = s[DATA_W-1:0];
    end
`else
    narrow = s[DATA_W-1:0];
`endif
  endfunction

  // Piecewise-linear sigmoid: (z >>> 2) + 0.5, clamped to [0, 1.0].
  function automatic logic signed [DATA_W-1:0] sigmoid_pwl(input logic signed [DATA_W-1:0] z);
    logic signed [DATA_W-1:0] t;
    t = (z >>> 2'd2) + Y_HALF;
    if (t[DATA_W-1]) begin
      sigmoid_pwl = {DATA_W{1'b0}};
    end else if (t > Y_ONE) begin
      sigmoid_pwl = Y_ONE;
    end else begin
      sigmoid_pwl = t;
    end
  endfunction

  assign cfg_ok_s   = cfg_we && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign mac_last_s = (idx_r == IW'(N_IN - 1));
  assign prod_s     = x_r[idx_r] * w_r[idx_r];
  assign term_s     = ACC_W'(prod_s >>> FRAC);
  assign sum_s      = acc_r + ACC_W'(bias_r);

  // Parameter store and input latch; deliberately unaffected by rst so weights survive it.
  always_ff @(posedge clk) begin
    if (cfg_ok_s) begin
      for (int i = 0; i < N_IN; i++) begin
        if (cfg_addr == AW'(i)) w_r[i] <= cfg_data;
      end
      if (cfg_addr == AW'(N_IN)) bias_r <= cfg_data;
    end
    if ((state_r == ST_IDLE) && req) begin
      for (int i = 0; i < N_IN; i++) begin
        x_r[i] <= x_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state decode; req is only sampled in IDLE and DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (req) state_nxt_s = ST_MAC;  else state_nxt_s = ST_IDLE;
      ST_MAC:  if (mac_last_s) state_nxt_s = ST_BIAS; else state_nxt_s = ST_MAC;
      ST_BIAS: state_nxt_s = ST_ACT;
      ST_ACT:  state_nxt_s = ST_DONE;
      ST_DONE: if (req) state_nxt_s = ST_DONE; else state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath next values per state: MAC step, bias/narrow, activation, handshake.
  always_comb begin
    acc_nxt_s = acc_r;
    idx_nxt_s = idx_r;
    z_nxt_s   = z_r;
    y_nxt_s   = y_r;
    ack_nxt_s = ack_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          acc_nxt_s = {ACC_W{1'b0}};
          idx_nxt_s = {IW{1'b0}};
        end else begin
          acc_nxt_s = acc_r;
        end
      end
      ST_MAC: begin
        acc_nxt_s = acc_r + term_s;
        if (mac_last_s) idx_nxt_s = {IW{1'b0}};
        else            idx_nxt_s = idx_r + IW'(1'b1);
      end
      ST_BIAS: z_nxt_s = narrow(sum_s);
      ST_ACT: begin
        y_nxt_s   = sigmoid_pwl(z_r);
        ack_nxt_s = 1'b1;
      end
      ST_DONE: begin
        if (req) ack_nxt_s = 1'b1;
        else     ack_nxt_s = 1'b0;
      end
      default: ack_nxt_s = 1'b0;
    endcase
  end

  // Datapath registers; rst discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
      idx_r <= {IW{1'b0}};
      ack_r <= 1'b0;
      z_r   <= {DATA_W{1'b0}};
      y_r   <= {DATA_W{1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
      idx_r <= idx_nxt_s;
      ack_r <= ack_nxt_s;
      z_r   <= z_nxt_s;
      y_r   <= y_nxt_s;
    end
  end

  assign ack   = ack_r;
  assign z_out = z_r;
  assign y_out = y_r;

endmodule

// File: tb/tb_sigmoid_output_layer.sv
// Scoreboard bench for sigmoid_output_layer (N_IN=2, Q3.4).
// Honours OUTLAYER_SAT_EN in its reference model.
module tb_sigmoid_output_layer;

  localparam int N_IN  = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int AW    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic [N_IN*DW-1:0]   x_in;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [DW-1:0]        cfg_data;
  logic                 ack;
  logic [DW-1:0]        z_out;
  logic [DW-1:0]        y_out;

  sigmoid_output_layer #(.N_IN(N_IN), .DATA_W(DW), .FRAC(4), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ack(ack), .z_out(z_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  int w_m [N_IN];
  int b_m;

  typedef struct { int z; int y; int c; } exp_t;
  exp_t sb_q [$];

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int wrap_to(input int v, input int bits);
    int m;
    int t;
    m = 1 << bits;
    t = v % m;
    if (t < 0) t = t + m;
    if (t >= m / 2) t = t - m;
    return t;
  endfunction

  // Reference: sum of floor(x*w/16), plus bias, wrapped to ACC_W, narrowed, then sigmoid.
  task automatic ref_model(input logic [N_IN*DW-1:0] xv, output int z, output int y);
    int s;
    int xi;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      xi = $signed(xv[i*DW +: DW]);
      s = s + floor_div(xi * w_m[i], 16);
    end
    s = wrap_to(s + b_m, ACC_W);
`ifdef OUTLAYER_SAT_EN
    if (s > 127) z = 127;
    else if (s < -128) z = -128;
    else z = s;
`else
    z = wrap_to(s, DW);
`endif
    y = floor_div(z, 4) + 8;
    if (y < 0) y = 0;
    if (y > 16) y = 16;
  endtask

  function automatic logic [N_IN*DW-1:0] pack2(input int a, input int b);
    logic [N_IN*DW-1:0] v;
    v = {b[7:0], a[7:0]};
    return v;
  endfunction

  // Monitor: on every rising ack, pop the scoreboard and compare.
  logic ack_d = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack === 1'b1 && ack_d !== 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 expected no result pending (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_z_out", $signed(z_out), e.z);
        check("sb_y_out", y_out, e.y);
        check("sb_ack_latency_cycle", cyc, e.c);
      end
    end
    ack_d <= ack;
  end

  task automatic cfg_write(input int addr, input logic [DW-1:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr[AW-1:0];
    cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < N_IN) w_m[addr] = $signed(data);
    else if (addr == N_IN) b_m = $signed(data);
  endtask

  task automatic start(input logic [N_IN*DW-1:0] xv, output int z, output int y);
    int cs;
    req = 1'b1;
    x_in = xv;
    @(negedge clk);
    cs = cyc;
    ref_model(xv, z, y);
    sb_q.push_back('{z, y, cs + N_IN + 2});
  endtask

  task automatic run_hold(input logic [N_IN*DW-1:0] xv, input bit poke);
    int z;
    int y;
    int n;
    start(xv, z, y);
    if (poke) begin
      cfg_we = 1'b1;
      cfg_addr = 2'd0;
      cfg_data = 8'h00;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    n = 0;
    while (ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ack !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got ack=%b expected 1 within 20 cycles", ack);
    end else begin
      repeat (2) begin
        @(negedge clk);
        check("ack_held", ack, 1);
        check("z_held", $signed(z_out), z);
      end
    end
    req = 1'b0;
    @(negedge clk);
    check("ack_cleared", ack, 0);
    check("z_kept_idle", $signed(z_out), z);
    check("y_kept_idle", y_out, y);
  endtask

  task automatic run_pulse(input logic [N_IN*DW-1:0] xv);
    int z;
    int y;
    start(xv, z, y);
    req = 1'b0;
    x_in = 16'($urandom);
    repeat (N_IN + 1) @(negedge clk);
    check("pulse_not_early", ack, 0);
    @(negedge clk);
    check("pulse_high", ack, 1);
    check("pulse_y", y_out, y);
    @(negedge clk);
    check("pulse_low", ack, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; x_in = '0;
    for (int i = 0; i < N_IN; i++) w_m[i] = 0;
    b_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ack", ack, 0);
    check("reset_z", $signed(z_out), 0);
    check("reset_y", y_out, 0);

    cfg_write(0, 8'hCC);   // -52
    cfg_write(1, 8'h30);   // 48
    cfg_write(2, 8'hF5);   // -11

    run_hold(pack2(16, 16), 1'b0);
    check("tp_basic_z", $signed(z_out), -15);
    check("tp_basic_y", y_out, 4);

    run_hold(pack2(0, 16), 1'b0);
    check("tp_upper_clamp_z", $signed(z_out), 37);
    check("tp_upper_clamp_y", y_out, 16);

    run_hold(pack2(-128, 127), 1'b0);
`ifdef OUTLAYER_SAT_EN
    check("tp_overflow_z", $signed(z_out), 127);
    check("tp_overflow_y", y_out, 16);
`else
    check("tp_overflow_z", $signed(z_out), 18);
    check("tp_overflow_y", y_out, 12);
`endif

    run_hold(pack2(127, -128), 1'b0);
`ifdef OUTLAYER_SAT_EN
    check("tp_underflow_z", $signed(z_out), -128);
`else
    check("tp_underflow_z", $signed(z_out), -40);
`endif
    check("tp_underflow_y", y_out, 0);

    // cfg write during MAC must be dropped
    run_hold(pack2(16, 16), 1'b1);
    check("tp_cfg_drop_z", $signed(z_out), -15);

    // reset during MAC
    req = 1'b1;
    x_in = pack2(16, 16);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ack", ack, 0);
    check("midrst_y", y_out, 0);
    check("midrst_z", $signed(z_out), 0);
    repeat (6) @(negedge clk);
    check("midrst_no_ack", ack, 0);
    run_hold(pack2(16, 16), 1'b0);
    check("tp_rerun_y", y_out, 4);

    // early release, x_in scrambled after sampling
    run_pulse(pack2(16, 16));
    check("tp_pulse_z", $signed(z_out), -15);

    // out-of-range cfg address is ignored
    cfg_write(3, 8'h7F);
    run_hold(pack2(16, 16), 1'b0);

    // randomized back-to-back traffic
    for (int it = 0; it < 24; it++) begin
      if (it % 4 == 0) begin
        for (int a = 0; a <= N_IN + 1; a++) cfg_write(a, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) == 1) run_pulse(16'($urandom));
      else run_hold(16'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
